// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: FSM states and access owner.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_BUSY = 2'd1,
    DMA_BUSY = 2'd2,
    DONE     = 2'd3
  } arb_state_t;

  typedef enum logic {
    CPU = 1'b0,
    DMA = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/sdram_arbiter.sv
// Shares the SDRAM adapter port between the CPU and a DMA master.
// CPU has priority; a streak limit forces a DMA grant so DMA is never starved.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 25,
  parameter int DATA_WIDTH     = 8,
  parameter int CPU_STREAK_MAX = 4
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_cpu_cs,
  input  logic                  i_cpu_rwb,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_data,
  output logic [DATA_WIDTH-1:0] o_cpu_data,
  output logic                  o_cpu_wait,
  input  logic                  i_dma_req,
  input  logic                  i_dma_rwb,
  input  logic [ADDR_WIDTH-1:0] i_dma_addr,
  input  logic [DATA_WIDTH-1:0] i_dma_data,
  output logic                  o_dma_ack,
  output logic [DATA_WIDTH-1:0] o_dma_data,
  output logic                  o_mem_req,
  output logic                  o_mem_rwb,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam int SW = $clog2(CPU_STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(CPU_STREAK_MAX);

  arb_state_t      state_r;
  arb_owner_t      owner_r;
  logic [SW-1:0]   streak_r;
  logic            grant_dma_s;

  // DMA wins when the CPU is silent or the CPU has used up its streak.
  always_comb begin
    grant_dma_s = 1'b0;
    if (i_dma_req && (!i_cpu_cs || (streak_r == STREAK_MAX))) begin
      grant_dma_s = 1'b1;
    end else begin
      grant_dma_s = 1'b0;
    end
  end

  // The stall must be combinational so the CPU halts on its very first SDRAM cycle.
  assign o_cpu_wait = i_cpu_cs && !((state_r == DONE) && (owner_r == CPU));

  // Arbitration FSM with registered adapter fields and completion outputs.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_r     <= IDLE;
      owner_r     <= CPU;
      streak_r    <= '0;
      o_mem_req   <= 1'b0;
      o_mem_rwb   <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_cpu_data  <= '0;
      o_dma_ack   <= 1'b0;
      o_dma_data  <= '0;
    end else begin
      o_dma_ack <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_dma_s) begin
            owner_r     <= DMA;
            o_mem_req   <= 1'b1;
            o_mem_rwb   <= i_dma_rwb;
            o_mem_addr  <= i_dma_addr;
            o_mem_wdata <= i_dma_data;
            streak_r    <= '0;
            state_r     <= DMA_BUSY;
          end else if (i_cpu_cs) begin
            owner_r     <= CPU;
            o_mem_req   <= 1'b1;
            o_mem_rwb   <= i_cpu_rwb;
            o_mem_addr  <= i_cpu_addr;
            o_mem_wdata <= i_cpu_data;
            state_r     <= CPU_BUSY;
            if (!i_dma_req) begin
              streak_r <= '0;
            end else if (streak_r != STREAK_MAX) begin
              streak_r <= streak_r + SW'(1);
            end else begin
              streak_r <= streak_r;
            end
          end else begin
            streak_r <= '0;
          end
        end
        CPU_BUSY: begin
          if (i_mem_ack) begin
            o_mem_req  <= 1'b0;
            o_cpu_data <= i_mem_rdata;
            state_r    <= DONE;
          end else begin
            state_r <= CPU_BUSY;
          end
        end
        DMA_BUSY: begin
          if (i_mem_ack) begin
            o_mem_req  <= 1'b0;
            o_dma_data <= i_mem_rdata;
            o_dma_ack  <= 1'b1;
            state_r    <= DONE;
          end else begin
            state_r <= DMA_BUSY;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          o_mem_req <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus a randomized
// run checked against a request-level arbitration model.
module tb_sdram_arbiter;

  localparam int AW   = 25;
  localparam int DW   = 8;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          cpu_cs, cpu_rwb, dma_req, dma_rwb, mem_ack;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, mem_rdata;
  logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata;
  logic          cpu_wait, dma_ack, mem_req, mem_rwb;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CPU_STREAK_MAX(SMAX)) dut (
    .i_clk(clk), .i_arst_n(arst_n),
    .i_cpu_cs(cpu_cs), .i_cpu_rwb(cpu_rwb), .i_cpu_addr(cpu_addr), .i_cpu_data(cpu_wdata),
    .o_cpu_data(cpu_rdata), .o_cpu_wait(cpu_wait),
    .i_dma_req(dma_req), .i_dma_rwb(dma_rwb), .i_dma_addr(dma_addr), .i_dma_data(dma_wdata),
    .o_dma_ack(dma_ack), .o_dma_data(dma_rdata),
    .o_mem_req(mem_req), .o_mem_rwb(mem_rwb), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Adapter model: waits for a request, holds for lat cycles, then acks with rd.
  task automatic serve(input int lat, input logic [DW-1:0] rd);
    int n;
    logic [AW-1:0] a;
    logic w;
    logic [DW-1:0] d;
    n = 0;
    while (!mem_req && n < 8) begin
      step();
      n++;
    end
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL serve_req_timeout: mem_req=%b required 1", mem_req);
    end
    a = mem_addr; w = mem_rwb; d = mem_wdata;
    for (int i = 0; i < lat; i++) begin
      step();
      checks++;
      if ({mem_req, mem_rwb, mem_addr, mem_wdata} !== {1'b1, w, a, d}) begin
        errors++;
        $display("FAIL busy_hold: req=%b rwb=%b addr=%h wdata=%h required 1 %b %h %h",
                 mem_req, mem_rwb, mem_addr, mem_wdata, w, a, d);
      end
    end
    mem_ack = 1'b1;
    mem_rdata = rd;
    step();
    mem_ack = 1'b0;
    mem_rdata = DW'($urandom);
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    cpu_cs = 1'b0; cpu_rwb = 1'b1; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_rwb = 1'b1; dma_addr = '0; dma_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    step();
    checks++;
    if ({mem_req, mem_rwb, mem_addr, mem_wdata, cpu_rdata, dma_ack, dma_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_values: req=%b rwb=%b addr=%h wd=%h cpu_d=%h dack=%b dma_d=%h required all 0",
               mem_req, mem_rwb, mem_addr, mem_wdata, cpu_rdata, dma_ack, dma_rdata);
    end
    cpu_cs = 1'b1;
    #1;
    checks++;
    if (cpu_wait !== 1'b1) begin
      errors++;
      $display("FAIL reset_wait_follows_cs: cpu_wait=%b required 1", cpu_wait);
    end
    cpu_cs = 1'b0;
    #1;
    checks++;
    if (cpu_wait !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait_follows_cs_low: cpu_wait=%b required 0", cpu_wait);
    end
    @(negedge clk);
    arst_n = 1'b1;
    step();
  endtask

  task automatic test_cpu_read();
    logic w [5];
    cpu_cs = 1'b1; cpu_rwb = 1'b1; cpu_addr = 25'h0000123; cpu_wdata = 8'h00;
    #1 w[0] = cpu_wait;
    step();
    w[1] = cpu_wait;
    checks++;
    if ({mem_req, mem_rwb, mem_addr} !== {1'b1, 1'b1, 25'h0000123}) begin
      errors++;
      $display("FAIL cpu_read_grant: req=%b rwb=%b addr=%h required 1 1 0000123", mem_req, mem_rwb, mem_addr);
    end
    step();
    w[2] = cpu_wait;
    step();
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    #1 w[3] = cpu_wait;
    step();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    w[4] = cpu_wait;
    checks++;
    if ({w[0], w[1], w[2], w[3], w[4]} !== 5'b11110) begin
      errors++;
      $display("FAIL cpu_read_wait_profile: got %b%b%b%b%b required 11110", w[0], w[1], w[2], w[3], w[4]);
    end
    checks++;
    if (cpu_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL cpu_read_data: cpu_data=%h required a5", cpu_rdata);
    end
    cpu_cs = 1'b0;
    step();
    checks++;
    if (mem_req !== 1'b0 || cpu_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL cpu_read_after: req=%b cpu_data=%h required 0 a5", mem_req, cpu_rdata);
    end
  endtask

  task automatic test_dma_write();
    int pulses;
    dma_req = 1'b1; dma_rwb = 1'b0; dma_addr = 25'h001F000; dma_wdata = 8'h3C;
    step();
    checks++;
    if ({mem_req, mem_rwb, mem_addr, mem_wdata} !== {1'b1, 1'b0, 25'h001F000, 8'h3C}) begin
      errors++;
      $display("FAIL dma_write_grant: req=%b rwb=%b addr=%h wd=%h required 1 0 001f000 3c",
               mem_req, mem_rwb, mem_addr, mem_wdata);
    end
    serve(3, 8'hEE);
    pulses = (dma_ack === 1'b1) ? 1 : 0;
    dma_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (dma_ack === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL dma_write_ack_pulses: got %0d required 1", pulses);
    end
  endtask

  task automatic test_streak();
    int n;
    logic is_dma, exp_dma;
    cpu_cs = 1'b1; cpu_rwb = 1'b1; cpu_addr = 25'h0000444;
    dma_req = 1'b1; dma_rwb = 1'b1; dma_addr = 25'h1555555;
    for (int g = 0; g < 10; g++) begin
      n = 0;
      while (!mem_req && n < 8) begin
        step();
        n++;
      end
      is_dma = (mem_addr === dma_addr);
      exp_dma = ((g % (SMAX + 1)) == SMAX);
      checks++;
      if (mem_req !== 1'b1 || is_dma !== exp_dma) begin
        errors++;
        $display("FAIL streak_order[%0d]: req=%b dma_granted=%b required 1 %b", g, mem_req, is_dma, exp_dma);
      end
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
    end
    cpu_cs = 1'b0; dma_req = 1'b0;
    step();
    step();
  endtask

  task automatic test_simultaneous();
    cpu_cs = 1'b1; cpu_rwb = 1'b1; cpu_addr = 25'h0000AAA;
    dma_req = 1'b1; dma_rwb = 1'b1; dma_addr = 25'h001BBBB;
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 25'h0000AAA) begin
      errors++;
      $display("FAIL simul_first_cpu: req=%b addr=%h required 1 0000aaa", mem_req, mem_addr);
    end
    serve(1, 8'h11);
    cpu_cs = 1'b0;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL simul_done_req: req=%b required 0", mem_req);
    end
    step();
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL simul_idle_req: req=%b required 0", mem_req);
    end
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 25'h001BBBB) begin
      errors++;
      $display("FAIL simul_dma_next: req=%b addr=%h required 1 001bbbb", mem_req, mem_addr);
    end
    serve(0, 8'h22);
    checks++;
    if (dma_ack !== 1'b1 || dma_rdata !== 8'h22) begin
      errors++;
      $display("FAIL simul_dma_done: ack=%b data=%h required 1 22", dma_ack, dma_rdata);
    end
    dma_req = 1'b0;
    step();
  endtask

  task automatic test_spurious_ack();
    logic [DW-1:0] keep;
    step();
    keep = cpu_rdata;
    mem_ack = 1'b1; mem_rdata = 8'h77;
    step();
    mem_ack = 1'b0;
    step();
    checks++;
    if (mem_req !== 1'b0 || dma_ack !== 1'b0 || cpu_rdata !== keep) begin
      errors++;
      $display("FAIL spurious_ack: req=%b dack=%b cpu_d=%h required 0 0 %h", mem_req, dma_ack, cpu_rdata, keep);
    end
    cpu_cs = 1'b1; cpu_rwb = 1'b0; cpu_addr = 25'h0000321; cpu_wdata = 8'h5A;
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 25'h0000321 || mem_wdata !== 8'h5A) begin
      errors++;
      $display("FAIL spurious_then_grant: req=%b addr=%h wd=%h required 1 0000321 5a", mem_req, mem_addr, mem_wdata);
    end
    serve(0, 8'h99);
    cpu_cs = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_dma();
    int pulses;
    dma_req = 1'b1; dma_rwb = 1'b1; dma_addr = 25'h0ABCDE0;
    step();
    step();
    arst_n = 1'b0;
    dma_req = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || dma_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_dma: req=%b dack=%b required 0 0", mem_req, dma_ack);
    end
    pulses = 0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (dma_ack === 1'b1 || mem_req === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_no_completion: activity cycles=%0d required 0", pulses);
    end
    dma_req = 1'b1; dma_rwb = 1'b1; dma_addr = 25'h0012345;
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 25'h0012345) begin
      errors++;
      $display("FAIL reset_regrant: req=%b addr=%h required 1 0012345", mem_req, mem_addr);
    end
    serve(1, 8'h6B);
    checks++;
    if (dma_ack !== 1'b1 || dma_rdata !== 8'h6B) begin
      errors++;
      $display("FAIL reset_regrant_done: ack=%b data=%h required 1 6b", dma_ack, dma_rdata);
    end
    dma_req = 1'b0;
    step();
  endtask

  // Request-level model: the CPU wins unless DMA is waiting and the CPU has
  // already taken SMAX grants in a row while DMA waited.
  task automatic test_random();
    bit cpu_p, dma_p, win_dma;
    int cpu_run;
    int lat;
    logic [DW-1:0] rd, cpu_data_m;
    logic [AW-1:0] exp_addr;
    logic exp_rwb;
    logic [DW-1:0] exp_wd;
    cpu_p = 1'b0; dma_p = 1'b0; cpu_run = 0;
    cpu_data_m = cpu_rdata;
    for (int r = 0; r < 80; r++) begin
      if (!cpu_p && ($urandom_range(1, 0) == 1)) begin
        cpu_p = 1'b1; cpu_cs = 1'b1; cpu_rwb = 1'($urandom);
        cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
      end
      if (!dma_p && ($urandom_range(1, 0) == 1)) begin
        dma_p = 1'b1; dma_req = 1'b1; dma_rwb = 1'($urandom);
        dma_addr = AW'($urandom); dma_wdata = DW'($urandom);
      end
      if (!cpu_p && !dma_p) begin
        cpu_p = 1'b1; cpu_cs = 1'b1; cpu_rwb = 1'b1;
        cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
      end
      win_dma = dma_p && (!cpu_p || cpu_run >= SMAX);
      if (win_dma) cpu_run = 0;
      else if (dma_p) cpu_run = (cpu_run >= SMAX) ? SMAX : cpu_run + 1;
      else cpu_run = 0;
      exp_addr = win_dma ? dma_addr : cpu_addr;
      exp_rwb = win_dma ? dma_rwb : cpu_rwb;
      exp_wd = win_dma ? dma_wdata : cpu_wdata;
      lat = $urandom_range(3, 0);
      rd = DW'($urandom);
      serve(lat, rd);
      checks++;
      if (mem_addr !== exp_addr || mem_rwb !== exp_rwb || mem_wdata !== exp_wd) begin
        errors++;
        $display("FAIL rand_winner[%0d]: addr=%h rwb=%b wd=%h required %h %b %h (dma=%b)",
                 r, mem_addr, mem_rwb, mem_wdata, exp_addr, exp_rwb, exp_wd, win_dma);
      end
      if (!win_dma) cpu_data_m = rd;
      checks++;
      if (mem_req !== 1'b0 || dma_ack !== win_dma || cpu_rdata !== cpu_data_m ||
          cpu_wait !== (win_dma && cpu_p)) begin
        errors++;
        $display("FAIL rand_done[%0d]: req=%b dack=%b cpu_d=%h wait=%b required 0 %b %h %b",
                 r, mem_req, dma_ack, cpu_rdata, cpu_wait, win_dma, cpu_data_m, win_dma && cpu_p);
      end
      if (win_dma && dma_rwb) begin
        checks++;
        if (dma_rdata !== rd) begin
          errors++;
          $display("FAIL rand_dma_data[%0d]: data=%h required %h", r, dma_rdata, rd);
        end
      end
      if (win_dma) begin
        dma_p = 1'b0; dma_req = 1'b0;
      end else begin
        cpu_p = 1'b0; cpu_cs = 1'b0;
      end
    end
    cpu_cs = 1'b0; dma_req = 1'b0;
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_simultaneous();
    test_streak();
    test_spurious_ack();
    test_reset_mid_dma();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
